// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder -- word-addressed RAM responder for the datapath memory port,
// with programmable wait states and a four-phase done handshake.
// Optional feature macro: MEM_RANGE_CHECK_EN (flags out-of-range addresses).
// Revision: 1.0 -- initial release
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       MAR_addr,
  input  logic [DATA_W-1:0] MDR_data,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WR_WAIT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mdatain_q, mdatain_d;
  logic              oor_q, oor_d;
  logic              ram_we;
  logic              addr_oor;

  logic [DATA_W-1:0] ram [DEPTH];

`ifdef MEM_RANGE_CHECK_EN
  assign addr_oor = |MAR_addr[31:ADDR_W];
`else
  // Upper address bits are ignored; the RAM simply wraps modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = ^MAR_addr[31:ADDR_W];
  assign addr_oor       = 1'b0;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      mdatain_q <= '0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      mdatain_q <= mdatain_d;
      oor_q     <= oor_d;
    end
  end

  // Storage is never reset; state_q is forced to IDLE by clear, so no write can land.
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx_q] <= wdata_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    mdatain_d = mdatain_q;
    oor_d     = oor_q;
    ram_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Read) begin
          state_d = S_RD_WAIT;
          cnt_d   = RD_LOAD;
          idx_d   = MAR_addr[ADDR_W-1:0];
          oor_d   = addr_oor;
        end else if (Write) begin
          state_d = S_WR_WAIT;
          cnt_d   = WR_LOAD;
          idx_d   = MAR_addr[ADDR_W-1:0];
          wdata_d = MDR_data;
          oor_d   = addr_oor;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = S_DONE;
          mdatain_d = oor_q ? '0 : ram[idx_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          ram_we  = ~oor_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        // A request still held here must drop for one edge before a new one is taken.
        if (!Read && !Write) begin
          state_d = S_IDLE;
          oor_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_busy = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
    mem_done = (state_q == S_DONE);
    mem_err  = (state_q == S_DONE) && oor_q;
  end

  assign Mdatain = mdatain_q;

endmodule

`default_nettype wire
